// File: rtl/rf_exec_unit.sv
// Four-cycle, non-pipelined execute/write-back controller for a 64x32 register file.
// Each accepted instruction goes IDLE -> READ -> EXEC -> WB, with the outputs registered on entry to each state.
module rf_exec_unit #(
    parameter int AddrSize = 6,
    parameter int DataSize = 32,
    parameter int CntSize  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [31:0]         inst,
    output logic                reg_enable,
    output logic                reg_write,
    output logic [AddrSize-1:0] src1_addr,
    output logic [AddrSize-1:0] src2_addr,
    output logic [AddrSize-1:0] write_addr,
    output logic [DataSize-1:0] write_data,
    input  logic [DataSize-1:0] src1,
    input  logic [DataSize-1:0] src2,
    output logic                done,
    output logic                err,
    output logic [CntSize-1:0]  retire_cnt
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t              state;
    logic [3:0]          op_reg;
    logic [5:0]          rd_reg;
    logic [9:0]          imm_reg;
    logic [DataSize-1:0] alu_out;
    logic [DataSize-1:0] imm_ext;
    logic [4:0]          shamt;

    assign imm_ext = {{(DataSize-10){imm_reg[9]}}, imm_reg};
    assign shamt   = src2[4:0];

    always_comb begin
        alu_out = '0;
        case (op_reg)
            4'd0:    alu_out = src1 + src2;
            4'd1:    alu_out = src1 - src2;
            4'd2:    alu_out = src1 & src2;
            4'd3:    alu_out = src1 | src2;
            4'd4:    alu_out = src1 ^ src2;
            4'd5:    alu_out = src1 << shamt;
            4'd6:    alu_out = src1 >> shamt;
            4'd7:    alu_out = src1 + imm_ext;
            default: alu_out = '0;
        endcase
    end

    // write_data doubles as the result register: it is loaded on the edge ending EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_reg     <= '0;
            rd_reg     <= '0;
            imm_reg    <= '0;
            inst_ready <= 1'b1;
            reg_enable <= 1'b0;
            reg_write  <= 1'b0;
            src1_addr  <= '0;
            src2_addr  <= '0;
            write_addr <= '0;
            write_data <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        state      <= READ;
                        op_reg     <= inst[31:28];
                        rd_reg     <= inst[27:22];
                        imm_reg    <= inst[9:0];
                        src1_addr  <= AddrSize'(inst[21:16]);
                        src2_addr  <= AddrSize'(inst[15:10]);
                        inst_ready <= 1'b0;
                        reg_enable <= 1'b1;
                        reg_write  <= 1'b0;
                    end
                end
                READ: begin
                    state      <= EXEC;
                    reg_enable <= 1'b0;
                end
                EXEC: begin
                    state      <= WB;
                    write_data <= alu_out;
                    write_addr <= AddrSize'(rd_reg);
                    reg_enable <= 1'b1;
                    reg_write  <= (op_reg <= 4'd7);
                    done       <= 1'b1;
                    err        <= (op_reg >= 4'd9);
                end
                WB: begin
                    state      <= IDLE;
                    inst_ready <= 1'b1;
                    reg_enable <= 1'b0;
                    reg_write  <= 1'b0;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    if (op_reg <= 4'd8)
                        retire_cnt <= retire_cnt + CntSize'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
